ddr3_rw_arbiter: RTL and testbench



---
 rtl/ddr3_pkg.sv | 36 +++
 rtl/ddr3_load_sync.sv | 22 ++
 rtl/ddr3_rw_arbiter.sv | 152 +++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared types, command codes and address helper for the DDR3 read/write arbiter.
package ddr3_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WRITE    = 2'd2,
    ST_READ     = 2'd3
  } arb_state_t;

  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  localparam logic [27:0] DEF_APP_ADDR_MIN = 28'd0;
  localparam logic [27:0] DEF_APP_ADDR_MAX = 28'd3_145_728;
  localparam logic [10:0] DEF_BURST_LEN    = 11'd64;
  localparam logic [27:0] DEF_ADDR_STEP    = 28'd8;
  localparam logic [10:0] DEF_RFIFO_LOW    = 11'd512;

  // Advance a frame pointer by one beat; the wrap compare uses the untruncated sum.
  function automatic logic [27:0] addr_advance(
    input logic [27:0] addr,
    input logic [27:0] step,
    input logic [27:0] amin,
    input logic [27:0] amax
  );
    logic [28:0] sum;
    sum = {1'b0, addr} + {1'b0, step};
    if (sum >= {1'b0, amax}) begin
      return amin;
    end else begin
      return sum[27:0];
    end
  endfunction

endpackage

// File: rtl/ddr3_load_sync.sv
// Brings an asynchronous frame signal into clk_100 and emits a one-cycle pulse on its rising edge.
module ddr3_load_sync (
  input  logic clk_100,
  input  logic rst,
  input  logic load,
  output logic pulse
);

  logic [2:0] sync_r;

  // Two synchroniser stages followed by one history stage for edge detection.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], load};
    end
  end

  assign pulse = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Arbitrates write and read bursts toward the MIG user interface and keeps
// wrapping frame pointers that are re-armed by the wr_load/rd_load frame signals.
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter logic [27:0] APP_ADDR_MIN = DEF_APP_ADDR_MIN,
  parameter logic [27:0] APP_ADDR_MAX = DEF_APP_ADDR_MAX,
  parameter logic [10:0] BURST_LEN    = DEF_BURST_LEN,
  parameter logic [27:0] ADDR_STEP    = DEF_ADDR_STEP,
  parameter logic [10:0] RFIFO_LOW    = DEF_RFIFO_LOW
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        init_calib_complete,
  input  logic        wr_load,
  input  logic        rd_load,
  input  logic [10:0] wfifo_rcount,
  input  logic [10:0] rfifo_wcount,
  input  logic        app_rdy,
  input  logic        app_wdf_rdy,
  input  logic        app_rd_data_valid,
  output logic        app_en,
  output logic [2:0]  app_cmd,
  output logic [27:0] app_addr,
  output logic        app_wdf_wren,
  output logic        app_wdf_end,
  output logic        wfifo_rden,
  output logic        rfifo_wren,
  output logic        busy
);

  arb_state_t  state_r, state_s;
  logic [27:0] wr_addr_r, rd_addr_r;
  logic [10:0] beat_cnt_r;
  logic        rd_armed_r, wr_reload_r, rd_reload_r;
  logic        wr_pulse_s, rd_pulse_s, wr_pend_s, rd_pend_s;
  logic        fire_w_s, fire_r_s, last_s, in_idle_s;

  ddr3_load_sync u_wr_sync (.clk_100(clk_100), .rst(rst), .load(wr_load), .pulse(wr_pulse_s));
  ddr3_load_sync u_rd_sync (.clk_100(clk_100), .rst(rst), .load(rd_load), .pulse(rd_pulse_s));

  // A beat only fires when calibration holds, so a calibration drop kills strobes that cycle.
  assign fire_w_s  = (state_r == ST_WRITE) & init_calib_complete & app_rdy & app_wdf_rdy;
  assign fire_r_s  = (state_r == ST_READ) & init_calib_complete & app_rdy;
  assign last_s    = (beat_cnt_r == (BURST_LEN - 11'd1));
  assign in_idle_s = (state_r == ST_IDLE);
  assign wr_pend_s = wr_reload_r | wr_pulse_s;
  assign rd_pend_s = rd_reload_r | rd_pulse_s;

  // Next-state decision: write wins, reads only once memory holds written data.
  always_comb begin
    state_s = state_r;
    if (!init_calib_complete) begin
      state_s = ST_WAIT_CAL;
    end else begin
      case (state_r)
        ST_WAIT_CAL: state_s = ST_IDLE;
        ST_IDLE: begin
          if (wfifo_rcount >= BURST_LEN) begin
            state_s = ST_WRITE;
          end else if ((rfifo_wcount < RFIFO_LOW) && rd_armed_r) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (fire_w_s && last_s) state_s = ST_IDLE;
          else                    state_s = ST_WRITE;
        end
        ST_READ: begin
          if (fire_r_s && last_s) state_s = ST_IDLE;
          else                    state_s = ST_READ;
        end
        default: state_s = ST_WAIT_CAL;
      endcase
    end
  end

  // MIG command/data strobes; idle value presents a read command at rd_addr.
  always_comb begin
    app_en       = 1'b0;
    app_cmd      = CMD_RD;
    app_addr     = rd_addr_r;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wfifo_rden   = 1'b0;
    case (state_r)
      ST_WRITE: begin
        app_en       = fire_w_s;
        app_cmd      = CMD_WR;
        app_addr     = wr_addr_r;
        app_wdf_wren = fire_w_s;
        app_wdf_end  = fire_w_s;
        wfifo_rden   = fire_w_s;
      end
      ST_READ: begin
        app_en = fire_r_s;
      end
      default: begin
        app_en = 1'b0;
      end
    endcase
  end

  // Returning read data is passed through whenever the controller is calibrated.
  assign rfifo_wren = app_rd_data_valid & (state_r != ST_WAIT_CAL);
  assign busy       = (state_r == ST_WRITE) | (state_r == ST_READ);

  // State register.
  always_ff @(posedge clk_100) begin
    if (rst) state_r <= ST_WAIT_CAL;
    else     state_r <= state_s;
  end

  // Frame pointers: a pending reload lands in IDLE, otherwise advance on each accepted beat.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      wr_addr_r <= APP_ADDR_MIN;
      rd_addr_r <= APP_ADDR_MIN;
    end else begin
      if (in_idle_s && wr_pend_s) wr_addr_r <= APP_ADDR_MIN;
      else if (fire_w_s)          wr_addr_r <= addr_advance(wr_addr_r, ADDR_STEP, APP_ADDR_MIN, APP_ADDR_MAX);
      if (in_idle_s && rd_pend_s) rd_addr_r <= APP_ADDR_MIN;
      else if (fire_r_s)          rd_addr_r <= addr_advance(rd_addr_r, ADDR_STEP, APP_ADDR_MIN, APP_ADDR_MAX);
    end
  end

  // Sticky reload flags, consumed in IDLE so an active burst keeps contiguous addresses.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      wr_reload_r <= 1'b0;
      rd_reload_r <= 1'b0;
    end else begin
      wr_reload_r <= wr_pend_s & ~in_idle_s;
      rd_reload_r <= rd_pend_s & ~in_idle_s;
    end
  end

  // Beat counter and read-arming after the first completed write burst.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      beat_cnt_r <= 11'd0;
      rd_armed_r <= 1'b0;
    end else begin
      if (!init_calib_complete)      beat_cnt_r <= 11'd0;
      else if (fire_w_s || fire_r_s) beat_cnt_r <= last_s ? 11'd0 : beat_cnt_r + 11'd1;
      if (fire_w_s && last_s)        rd_armed_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Directed bench for ddr3_rw_arbiter with a 1024-unit frame so wrapping is reachable.
module tb_ddr3_rw_arbiter;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic        init_calib_complete = 1'b0;
  logic        wr_load = 1'b0, rd_load = 1'b0;
  logic [10:0] wfifo_rcount = 11'd0, rfifo_wcount = 11'd1000;
  logic        app_rdy = 1'b1, app_wdf_rdy = 1'b1, app_rd_data_valid = 1'b0;
  logic        app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren, busy;
  logic [2:0]  app_cmd;
  logic [27:0] app_addr;

  int checks = 0;
  int failures = 0;

  ddr3_rw_arbiter #(.APP_ADDR_MAX(28'd1024)) dut (
    .clk_100(clk_100), .rst(rst), .init_calib_complete(init_calib_complete),
    .wr_load(wr_load), .rd_load(rd_load), .wfifo_rcount(wfifo_rcount),
    .rfifo_wcount(rfifo_wcount), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .wfifo_rden(wfifo_rden), .rfifo_wren(rfifo_wren), .busy(busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic do_reset();
    @(negedge clk_100);
    rst = 1'b1; init_calib_complete = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    wfifo_rcount = 11'd0; rfifo_wcount = 11'd1000;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    app_rd_data_valid = 1'b1;
    #1;
    checks++;
    if (app_en !== 1'b0 || app_cmd !== 3'b001 || app_addr !== 28'd0 || busy !== 1'b0 ||
        wfifo_rden !== 1'b0 || app_wdf_wren !== 1'b0 || rfifo_wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: en=%b cmd=%b addr=%0d busy=%b rden=%b wren=%b rfwren=%b required 0/001/0/0/0/0/0",
               app_en, app_cmd, app_addr, busy, wfifo_rden, app_wdf_wren, rfifo_wren);
    end
    checks++;
    if (dut.wr_addr_r !== 28'd0 || dut.rd_addr_r !== 28'd0) begin
      failures++;
      $display("FAIL reset_ptrs: wr=%0d rd=%0d required 0/0", dut.wr_addr_r, dut.rd_addr_r);
    end
    app_rd_data_valid = 1'b0;
  endtask

  task automatic test_cal_gate();
    int en_seen = 0;
    do_reset();
    wfifo_rcount = 11'd100;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_100); #1;
      if (app_en) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin
      failures++;
      $display("FAIL cal_gate: app_en high %0d cycles, required 0", en_seen);
    end
    @(negedge clk_100);
    init_calib_complete = 1'b1;
    @(posedge clk_100); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cal_idle_cycle: busy=%b required 0", busy);
    end
    @(posedge clk_100); #1;
    checks++;
    if (busy !== 1'b1 || app_en !== 1'b1 || app_cmd !== 3'b000) begin
      failures++;
      $display("FAIL cal_write_entry: busy=%b en=%b cmd=%b required 1/1/000", busy, app_en, app_cmd);
    end
  endtask

  task automatic test_no_read_unarmed();
    int en_seen = 0;
    do_reset();
    init_calib_complete = 1'b1;
    rfifo_wcount = 11'd100;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_100); #1;
      if (app_en) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin
      failures++;
      $display("FAIL unarmed_read: app_en high %0d cycles, required 0", en_seen);
    end
    rfifo_wcount = 11'd1000;
  endtask

  task automatic test_write_burst();
    int beats = 0;
    int bad = 0;
    do_reset();
    init_calib_complete = 1'b1;
    wfifo_rcount = 11'd64;
    for (int cyc = 0; cyc < 90; cyc++) begin
      @(negedge clk_100);
      if (beats >= 64) wfifo_rcount = 11'd0;
      #1;
      if (app_en) begin
        if (app_addr !== 28'(beats * 8) || app_cmd !== 3'b000 || wfifo_rden !== 1'b1 ||
            app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin
          bad++;
          if (bad < 4) $display("FAIL wr_beat: beat=%0d addr=%0d cmd=%b required addr=%0d cmd=000",
                                beats, app_addr, app_cmd, beats * 8);
        end
        beats++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (beats != 64) begin
      failures++;
      $display("FAIL wr_beat_count: got %0d required 64", beats);
    end
    checks++;
    if (dut.wr_addr_r !== 28'd512) begin
      failures++;
      $display("FAIL wr_final_addr: got %0d required 512", dut.wr_addr_r);
    end
  endtask

  task automatic test_wrap_reload();
    logic [27:0] starts [3];
    logic [27:0] exp_addr;
    int beats, bad;
    starts[0] = 28'd512; starts[1] = 28'd0; starts[2] = 28'd0;
    for (int b = 0; b < 3; b++) begin
      beats = 0; bad = 0;
      @(negedge clk_100);
      wfifo_rcount = 11'd64;
      for (int cyc = 0; cyc < 90; cyc++) begin
        @(negedge clk_100);
        if (beats >= 64) wfifo_rcount = 11'd0;
        wr_load = (b == 1 && beats >= 20 && beats < 24) ? 1'b1 : 1'b0;
        #1;
        if (app_en) begin
          exp_addr = starts[b] + 28'(beats * 8);
          if (exp_addr >= 28'd1024) exp_addr = exp_addr - 28'd1024;
          if (app_addr !== exp_addr || app_cmd !== 3'b000) begin
            bad++;
            if (bad < 4) $display("FAIL wrap_beat: burst=%0d beat=%0d addr=%0d required %0d",
                                  b, beats, app_addr, exp_addr);
          end
          beats++;
        end
      end
      checks++;
      if (bad != 0 || beats != 64) begin
        failures++;
        $display("FAIL wrap_burst: burst=%0d beats=%0d bad=%0d required 64/0", b, beats, bad);
      end
      if (b == 0) begin
        checks++;
        if (dut.wr_addr_r !== 28'd0) begin
          failures++;
          $display("FAIL wrap_end_addr: got %0d required 0", dut.wr_addr_r);
        end
      end
    end
    wr_load = 1'b0;
  endtask

  task automatic test_backpressure();
    int beats = 0;
    int stalls = 0;
    int bad = 0;
    do_reset();
    init_calib_complete = 1'b1;
    wfifo_rcount = 11'd64;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk_100);
      if (beats >= 64) wfifo_rcount = 11'd0;
      if (beats == 10 && stalls < 5) begin
        app_wdf_rdy = 1'b0; stalls++;
      end else begin
        app_wdf_rdy = 1'b1;
      end
      #1;
      if (!app_wdf_rdy) begin
        if (app_en !== 1'b0 || wfifo_rden !== 1'b0 || app_wdf_wren !== 1'b0 || app_addr !== 28'd80) begin
          bad++;
          $display("FAIL bp_hold: en=%b rden=%b wren=%b addr=%0d required 0/0/0/80",
                   app_en, wfifo_rden, app_wdf_wren, app_addr);
        end
      end else if (app_en) begin
        if (app_addr !== 28'(beats * 8)) begin
          bad++;
          $display("FAIL bp_beat: beat=%0d addr=%0d required %0d", beats, app_addr, beats * 8);
        end
        beats++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (beats != 64 || stalls != 5) begin
      failures++;
      $display("FAIL bp_count: beats=%0d stalls=%0d required 64/5", beats, stalls);
    end
  endtask

  task automatic test_read();
    int beats = 0, vsent = 0, wcnt = 0, bad = 0;
    @(negedge clk_100);
    wfifo_rcount = 11'd0;
    rfifo_wcount = 11'd100;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_100);
      if (beats >= 64) rfifo_wcount = 11'd1000;
      app_rd_data_valid = ((cyc % 2) == 1 && vsent < 64) ? 1'b1 : 1'b0;
      if (app_rd_data_valid) vsent++;
      #1;
      if (app_en) begin
        if (app_cmd !== 3'b001 || app_addr !== 28'(beats * 8) || busy !== 1'b1 || wfifo_rden !== 1'b0) begin
          bad++;
          if (bad < 4) $display("FAIL rd_beat: beat=%0d cmd=%b addr=%0d required 001/%0d",
                                beats, app_cmd, app_addr, beats * 8);
        end
        beats++;
      end
      if (rfifo_wren) wcnt++;
    end
    app_rd_data_valid = 1'b0;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (beats != 64) begin
      failures++;
      $display("FAIL rd_cmd_count: got %0d required 64", beats);
    end
    checks++;
    if (wcnt != 64) begin
      failures++;
      $display("FAIL rfifo_wren_count: got %0d required 64", wcnt);
    end
    checks++;
    if (dut.rd_addr_r !== 28'd512) begin
      failures++;
      $display("FAIL rd_final_addr: got %0d required 512", dut.rd_addr_r);
    end
  endtask

  task automatic test_priority();
    int found = 0;
    logic [2:0] first_cmd = 3'b111;
    @(negedge clk_100);
    wfifo_rcount = 11'd64;
    rfifo_wcount = 11'd100;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk_100); #1;
      if (app_en && found == 0) begin
        first_cmd = app_cmd; found = 1;
      end
    end
    checks++;
    if (found != 1 || first_cmd !== 3'b000) begin
      failures++;
      $display("FAIL priority: found=%0d first_cmd=%b required 1/000", found, first_cmd);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    do_reset();
    init_calib_complete = 1'b1;
    wfifo_rcount = 11'd64;
    for (int cyc = 0; cyc < 60 && beats < 30; cyc++) begin
      @(negedge clk_100); #1;
      if (app_en) beats++;
    end
    @(negedge clk_100);
    rst = 1'b1;
    @(posedge clk_100); #1;
    checks++;
    if (beats != 30 || app_en !== 1'b0 || busy !== 1'b0 || app_addr !== 28'd0 || dut.wr_addr_r !== 28'd0) begin
      failures++;
      $display("FAIL reset_mid_burst: beats=%0d en=%b busy=%b addr=%0d wr_addr=%0d required 30/0/0/0/0",
               beats, app_en, busy, app_addr, dut.wr_addr_r);
    end
    @(negedge clk_100);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cal_gate();
    test_no_read_unarmed();
    test_write_burst();
    test_wrap_reload();
    test_backpressure();
    test_read();
    test_priority();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
